// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - glyph codes and selector FSM states shared with the LCD block
package lcd_pkg;

    localparam logic [1:0] MOOD_SAD     = 2'b00;
    localparam logic [1:0] MOOD_HAPPY   = 2'b01;
    localparam logic [1:0] MOOD_NEUTRAL = 2'b10;

    localparam logic [1:0] STAT_HEALTH = 2'b00;
    localparam logic [1:0] STAT_ENERGY = 2'b01;
    localparam logic [1:0] STAT_FOOD   = 2'b10;
    localparam logic [1:0] STAT_FUN    = 2'b11;

    localparam logic [1:0] BOOT = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;

    function automatic logic [1:0] stat_code(input logic [1:0] idx);
        case (idx)
            2'd0:    return STAT_HEALTH;
            2'd1:    return STAT_ENERGY;
            2'd2:    return STAT_FOOD;
            default: return STAT_FUN;
        endcase
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running divider producing a one-cycle tick
module tick_prescaler #(
    parameter int TICK_MAX = 50000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);
    localparam int CW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_MAX - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lcd_figure_selector.sv
// rtl/lcd_figure_selector.sv - maps pet stat levels to the LCD mood/icon select code
module lcd_figure_selector
    import lcd_pkg::*;
#(
    parameter int STAT_W        = 4,
    parameter int STAT_MAX      = 10,
    parameter int LOW_THR       = 3,
    parameter int HIGH_THR      = 7,
    parameter int TICK_MAX      = 50000000,
    parameter int ROTATE_TICKS  = 3,
    parameter int POWERUP_TICKS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [STAT_W-1:0] health_i,
    input  logic [STAT_W-1:0] energy_i,
    input  logic [STAT_W-1:0] food_i,
    input  logic [STAT_W-1:0] fun_i,
    input  logic              hold_i,
    output logic [3:0]        select_figures,
    output logic              ready_o,
    output logic              alert_o,
    output logic              tick_o
);
    localparam logic [STAT_W-1:0] MAX_V  = STAT_W'(STAT_MAX);
    localparam logic [STAT_W-1:0] LOW_V  = STAT_W'(LOW_THR);
    localparam logic [STAT_W-1:0] HIGH_V = STAT_W'(HIGH_THR);
    localparam int RW = (ROTATE_TICKS > 1) ? $clog2(ROTATE_TICKS) : 1;
    localparam int BW = (POWERUP_TICKS > 1) ? $clog2(POWERUP_TICKS) : 1;
    localparam logic [RW-1:0] ROT_LAST  = RW'(ROTATE_TICKS - 1);
    localparam logic [BW-1:0] BOOT_LAST = BW'(POWERUP_TICKS - 1);
    localparam logic [3:0] SEL_RESET = {MOOD_NEUTRAL, STAT_HEALTH};

    logic              tick;
    logic [STAT_W-1:0] s [4];
    logic              crit, all_high;
    logic [1:0]        mood, lowest;

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] boot_q, boot_d;
    logic [RW-1:0] rot_q, rot_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    sel_q, sel_d;
    logic          ready_q, ready_d;
    logic          alert_q, alert_d;

    tick_prescaler #(.TICK_MAX(TICK_MAX)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    assign tick_o         = tick;
    assign select_figures = sel_q;
    assign ready_o        = ready_q;
    assign alert_o        = alert_q;

    // Ties on the minimum keep the lower index because only a strictly smaller value replaces it.
    always_comb begin : stat_eval
        s[0] = (health_i > MAX_V) ? MAX_V : health_i;
        s[1] = (energy_i > MAX_V) ? MAX_V : energy_i;
        s[2] = (food_i   > MAX_V) ? MAX_V : food_i;
        s[3] = (fun_i    > MAX_V) ? MAX_V : fun_i;
        crit     = 1'b0;
        all_high = 1'b1;
        lowest   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (s[i] <= LOW_V) crit = 1'b1;
            if (s[i] < HIGH_V) all_high = 1'b0;
            if (s[i] < s[lowest]) lowest = 2'(i);
        end
        if (crit)          mood = MOOD_SAD;
        else if (all_high) mood = MOOD_HAPPY;
        else               mood = MOOD_NEUTRAL;
    end

    always_comb begin : next_state
        state_d = state_q;
        boot_d  = boot_q;
        rot_d   = rot_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        ready_d = ready_q;
        alert_d = alert_q;
        if (tick) begin
            case (state_q)
                BOOT: begin
                    if (boot_q == BOOT_LAST) begin
                        ready_d = 1'b1;
                        state_d = RUN;
                    end else begin
                        boot_d = boot_q + BW'(1);
                    end
                end
                RUN: begin
                    if (crit) begin
                        idx_d = lowest;
                        rot_d = '0;
                    end else if (!hold_i) begin
                        if (rot_q == ROT_LAST) begin
                            idx_d = idx_q + 2'd1;
                            rot_d = '0;
                        end else begin
                            rot_d = rot_q + RW'(1);
                        end
                    end
                    sel_d   = {mood, stat_code(idx_d)};
                    alert_d = crit;
                end
                default: begin
                    state_d = BOOT;
                    boot_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            boot_q  <= '0;
            rot_q   <= '0;
            idx_q   <= 2'd0;
            sel_q   <= SEL_RESET;
            ready_q <= 1'b0;
            alert_q <= 1'b0;
        end else begin
            state_q <= state_d;
            boot_q  <= boot_d;
            rot_q   <= rot_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            ready_q <= ready_d;
            alert_q <= alert_d;
        end
    end

endmodule

// File: tb/tb_lcd_figure_selector.sv
// tb/tb_lcd_figure_selector.sv - vector table, reset sequence and random run against a reference model
module tb_lcd_figure_selector;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] health, energy, food, fun;
    logic       hold;
    logic [3:0] select_figures;
    logic       ready, alert, tick;

    int n_assert = 0;
    int n_fail   = 0;

    int         m_cyc, m_ticks, m_idx, m_rot;
    bit         m_ready, m_alert;
    logic [3:0] m_sel;

    typedef struct {
        int         h, e, f, u;
        bit         hold;
        int         ticks;
        logic [3:0] sel;
        bit         alert;
    } vec_t;
    vec_t vt[$];

    lcd_figure_selector #(
        .STAT_W(4), .STAT_MAX(10), .LOW_THR(3), .HIGH_THR(7),
        .TICK_MAX(4), .ROTATE_TICKS(3), .POWERUP_TICKS(2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .health_i       (health),
        .energy_i       (energy),
        .food_i         (food),
        .fun_i          (fun),
        .hold_i         (hold),
        .select_figures (select_figures),
        .ready_o        (ready),
        .alert_o        (alert),
        .tick_o         (tick)
    );

    always #5 clk = ~clk;

    a_sel_on_tick: assert property (@(posedge clk) disable iff (reset)
        (select_figures == $past(select_figures)) || $past(tick))
        n_assert++;
    else begin
        n_assert++;
        n_fail++;
        $display("FAIL sel_on_tick: select_figures changed to %b outside a tick cycle", select_figures);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
        return (v > 10) ? 10 : v;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_ticks = 0; m_idx = 0; m_rot = 0;
        m_ready = 0; m_alert = 0; m_sel = 4'b1000;
    endtask

    // One clock edge of the behavioural model: stats only matter on the tick edge.
    task automatic model_edge();
        int s [4];
        int mn, low, mood_v;
        bit crit, is_tick;
        is_tick = (m_cyc % 4) == 3;
        m_cyc++;
        if (!is_tick) return;
        s[0] = clampv(int'(health)); s[1] = clampv(int'(energy));
        s[2] = clampv(int'(food));   s[3] = clampv(int'(fun));
        mn = 99; low = 0;
        for (int i = 0; i < 4; i++) if (s[i] < mn) begin mn = s[i]; low = i; end
        crit   = (mn <= 3);
        mood_v = crit ? 0 : ((mn >= 7) ? 1 : 2);
        m_ticks++;
        if (!m_ready) begin
            if (m_ticks >= 2) m_ready = 1;
            return;
        end
        if (crit) begin
            m_idx = low; m_rot = 0;
        end else if (!hold) begin
            m_rot++;
            if (m_rot == 3) begin m_rot = 0; m_idx = (m_idx + 1) % 4; end
        end
        m_sel   = 4'(mood_v * 4 + m_idx);
        m_alert = crit;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("sel", 32'(select_figures), 32'(m_sel));
        chk("ready", 32'(ready), 32'(m_ready));
        chk("alert", 32'(alert), 32'(m_alert));
        chk("tick", 32'(tick), 32'((m_cyc % 4) == 3));
    endtask

    task automatic set_stats(input int h, input int e, input int f, input int u, input bit hd);
        health = 4'(h); energy = 4'(e); food = 4'(f); fun = 4'(u); hold = hd;
    endtask

    task automatic add(input int h, input int e, input int f, input int u, input bit hd,
                       input int t, input logic [3:0] sel, input bit al);
        vec_t v;
        v.h = h; v.e = e; v.f = f; v.u = u; v.hold = hd; v.ticks = t; v.sel = sel; v.alert = al;
        vt.push_back(v);
    endtask

    task automatic async_reset_check();
        reset = 1'b1;
        #1;
        chk("rst_sel", 32'(select_figures), 32'h8);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_alert", 32'(alert), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        add(5, 5, 5, 5, 0, 2, 4'b1000, 0);
        add(5, 5, 5, 5, 0, 1, 4'b1001, 0);
        add(5, 5, 5, 5, 0, 2, 4'b1001, 0);
        add(5, 5, 5, 5, 0, 1, 4'b1010, 0);
        add(5, 5, 5, 5, 0, 2, 4'b1010, 0);
        add(5, 5, 5, 5, 0, 1, 4'b1011, 0);
        add(5, 5, 5, 5, 0, 2, 4'b1011, 0);
        add(5, 5, 5, 5, 0, 1, 4'b1000, 0);
        add(9, 9, 9, 9, 0, 1, 4'b0100, 0);
        add(9, 7, 9, 9, 0, 1, 4'b0100, 0);
        add(9, 6, 9, 9, 0, 1, 4'b1001, 0);
        add(8, 8, 2, 2, 0, 1, 4'b0010, 1);
        add(8, 8, 2, 2, 0, 3, 4'b0010, 1);
        add(8, 8, 9, 2, 0, 1, 4'b0011, 1);
        add(8, 8, 9, 9, 0, 2, 4'b0111, 0);
        add(8, 8, 9, 9, 0, 1, 4'b0100, 0);
        add(15, 10, 10, 10, 1, 10, 4'b0100, 0);
        add(15, 10, 10, 1, 1, 1, 4'b0011, 1);
        add(5, 5, 5, 5, 0, 1, 4'b1011, 0);

        reset = 1'b1;
        set_stats(9, 9, 9, 9, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("init_sel", 32'(select_figures), 32'h8);
        chk("init_ready", 32'(ready), 32'h0);
        reset = 1'b0;
        model_reset();

        repeat (14) step();
        chk("pre_reset_happy", 32'(select_figures), 32'h4);
        async_reset_check();
        for (int k = 0; k < 8; k++) begin
            step();
            if (k < 7) chk("ready_early", 32'(ready), 32'h0);
            else       chk("ready_rise", 32'(ready), 32'h1);
        end

        foreach (vt[i]) begin
            set_stats(vt[i].h, vt[i].e, vt[i].f, vt[i].u, vt[i].hold);
            repeat (vt[i].ticks * 4) step();
            chk($sformatf("vec%0d_sel", i), 32'(select_figures), 32'(vt[i].sel));
            chk($sformatf("vec%0d_alert", i), 32'(alert), 32'(vt[i].alert));
        end

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset_check();
            end else if ($urandom_range(0, 2) == 0) begin
                health = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(4, 15));
                energy = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(4, 15));
                food   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(4, 15));
                fun    = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(4, 15));
                hold   = ($urandom_range(0, 3) == 0);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
